// File: rtl/sum_disp_pkg.sv
// Shared types and constants for the sum display driver: state encoding,
// active-high 7-segment patterns {g,f,e,d,c,b,a}, widths, and one
// shift-add-3 step of the binary-to-BCD converter.
package sum_disp_pkg;
  localparam int BCD_W = 4;
  localparam int BIN_W = 5;
  localparam int SR_W  = 2*BCD_W + BIN_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One conversion step on {tens, units, bin}: correct each BCD nibble
  // that would overflow when doubled, then shift the whole register left.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    if (t[SR_W-1 -: BCD_W] >= 4'd5)
      t[SR_W-1 -: BCD_W] = t[SR_W-1 -: BCD_W] + 4'd3;
    if (t[BIN_W+BCD_W-1 -: BCD_W] >= 4'd5)
      t[BIN_W+BCD_W-1 -: BCD_W] = t[BIN_W+BCD_W-1 -: BCD_W] + 4'd3;
    return {t[SR_W-2:0], 1'b0};
  endfunction
endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD to 7-segment encoder, active-high output.
// Values above 9 and an asserted blank input both produce an unlit digit.
module seg7_encoder
  import sum_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  input  logic             blank_i,
  output logic [6:0]       seg_o
);

  // Pattern lookup; blank wins over the digit value.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_display_driver.sv
// Binary sum (0..31) to two BCD digits via a 5-step shift-add-3 FSM, driving
// a time-multiplexed two-digit 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN: blank the tens digit when it is 0.
module sum_display_driver
  import sum_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [BIN_W-1:0] Din,
  output logic [6:0]       Seg,
  output logic [1:0]       Com,
  output logic [BCD_W-1:0] Tens,
  output logic [BCD_W-1:0] Units,
  output logic             Busy
);

  localparam int         CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d, sr_step;
  logic [2:0]        step_q, step_d;
  logic [BIN_W-1:0]  cap_q, cap_d;
  logic [BIN_W-1:0]  last_q, last_d;
  logic [BCD_W-1:0]  tens_q, tens_d;
  logic [BCD_W-1:0]  units_q, units_d;
  logic              busy_q, busy_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        com_q;
  logic [6:0]        seg_q;
  logic              tick, sel_tens, enc_blank;
  logic [BCD_W-1:0]  enc_digit;
  logic [6:0]        enc_seg;

  assign sr_step = dd_step(sr_q);

  // Conversion FSM next-state: start on a changed input, finish after 5 steps.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    step_d  = step_q;
    cap_d   = cap_q;
    last_d  = last_q;
    tens_d  = tens_q;
    units_d = units_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (Din != last_q) begin
          sr_d    = {{(2*BCD_W){1'b0}}, Din};
          step_d  = 3'd0;
          cap_d   = Din;
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        sr_d   = sr_step;
        step_d = step_q + 3'd1;
        if (step_q == 3'd4) begin
          tens_d  = sr_step[SR_W-1 -: BCD_W];
          units_d = sr_step[BIN_W+BCD_W-1 -: BCD_W];
          last_d  = cap_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Conversion FSM state and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      step_q  <= '0;
      cap_q   <= '0;
      last_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      step_q  <= step_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      busy_q  <= busy_d;
    end
  end

  // The digit about to be selected: tens follows units, anything else
  // (including the all-off reset state) goes to units.
  assign tick      = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign sel_tens  = (com_q == 2'b01);
  assign enc_digit = sel_tens ? tens_q : units_q;
`ifdef LEADING_ZERO_BLANK_EN
  assign enc_blank = sel_tens && (tens_q == '0);
`else
  assign enc_blank = 1'b0;
`endif

  seg7_encoder u_enc (
    .bcd_i   (enc_digit),
    .blank_i (enc_blank),
    .seg_o   (enc_seg)
  );

  // Scan counter; each wrap switches the digit and latches its pattern.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      com_q <= 2'b00;
      seg_q <= SEG_OFF;
    end else if (tick) begin
      cnt_q <= '0;
      com_q <= sel_tens ? 2'b10 : 2'b01;
      seg_q <= SEG_ACTIVE_LOW ? ~enc_seg : enc_seg;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Seg   = seg_q;
  assign Com   = com_q;
  assign Tens  = tens_q;
  assign Units = units_q;
  assign Busy  = busy_q;

endmodule

// File: tb/tb_sum_display_driver.sv
// Self-checking bench for sum_display_driver (SCAN_DIV=4, active-low segments).
// Build with LEADING_ZERO_BLANK_EN defined to exercise tens-digit blanking.
module tb_sum_display_driver;
  localparam int SCAN_DIV = 4;
  localparam bit SAL      = 1'b1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [4:0] Din = '0;
  logic [6:0] Seg;
  logic [1:0] Com;
  logic [3:0] Tens, Units;
  logic       Busy;

  int total = 0;
  int bad   = 0;

  sum_display_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(SAL)) dut (
    .CLK(CLK), .RST(RST), .Din(Din), .Seg(Seg), .Com(Com),
    .Tens(Tens), .Units(Units), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Active-high digit patterns {g,f,e,d,c,b,a}.
  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] pin_pattern(input int d, input bit blank);
    logic [6:0] p;
    p = blank ? 7'h00 : seg_tbl[d];
    return SAL ? ~p : p;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: digits by div/mod, conversion modelled as a 5-cycle
  // busy window, scan as a cycle count since reset.
  int         m_last, m_cap, m_steps, m_tens, m_units, m_cnt;
  bit         m_busy;
  logic [1:0] m_com;
  logic [6:0] m_seg;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_last = 0; m_cap = 0; m_steps = 0; m_tens = 0; m_units = 0;
      m_cnt = 0; m_busy = 0; m_com = 2'b00; m_seg = pin_pattern(0, 1'b1);
    end else begin
      if (m_cnt == SCAN_DIV - 1) begin
        bit to_tens;
        bit blank;
        m_cnt   = 0;
        to_tens = (m_com == 2'b01);
        blank   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank   = to_tens && (m_tens == 0);
`endif
        m_com = to_tens ? 2'b10 : 2'b01;
        m_seg = pin_pattern(to_tens ? m_tens : m_units, blank);
      end else begin
        m_cnt++;
      end
      if (m_busy) begin
        m_steps++;
        if (m_steps == 5) begin
          m_tens = m_cap / 10; m_units = m_cap % 10;
          m_last = m_cap; m_busy = 0;
        end
      end else if (int'(Din) != m_last) begin
        m_cap = int'(Din); m_steps = 0; m_busy = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  bit cmp_en = 1'b0;
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("m_busy",  Busy,  m_busy);
      chk("m_tens",  Tens,  m_tens);
      chk("m_units", Units, m_units);
      chk("m_com",   Com,   m_com);
      chk("m_seg",   Seg,   m_seg);
    end
  end

  // Apply a new Din before the next edge, then step past its 5-step conversion.
  task automatic convert(input int v);
    @(negedge CLK);
    Din = 5'(v);
    repeat (6) @(negedge CLK);
  endtask

  // Wait (bounded) for the given digit select, then check the pattern.
  task automatic slot(input string name, input logic [1:0] c, input int exp_seg);
    int n;
    n = 0;
    while (Com !== c && n < 4*SCAN_DIV) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_com"}, Com, c);
    chk({name, "_seg"}, Seg, exp_seg);
  endtask

  initial begin
    // 1: reset and idle display
    repeat (3) @(negedge CLK);
    chk("rst_com", Com, 0);
    chk("rst_seg", Seg, 7'h7F);
    chk("rst_busy", Busy, 0);
    cmp_en = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    chk("pre_tick_com", Com, 0);
    chk("pre_tick_seg", Seg, 7'h7F);
    repeat (3) @(negedge CLK);
    chk("tick1_com", Com, 2'b01);
    chk("tick1_seg", Seg, 7'h40);

    // 2: 0 -> 18, busy window and digits
    @(negedge CLK);
    Din = 5'd18;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("t2_busy_hi", Busy, 1);
    end
    @(negedge CLK);
    chk("t2_busy_lo", Busy, 0);
    chk("t2_tens", Tens, 1);
    chk("t2_units", Units, 8);
    repeat (2*SCAN_DIV) @(negedge CLK);
    slot("t2_units_slot", 2'b01, 7'h00);
    slot("t2_tens_slot",  2'b10, 7'h79);

    // 3: change during conversion is picked up afterwards
    @(negedge CLK);
    Din = 5'd7;
    @(negedge CLK);
    @(negedge CLK);
    Din = 5'd12;
    repeat (4) @(negedge CLK);
    chk("t3_first_tens", Tens, 0);
    chk("t3_first_units", Units, 7);
    chk("t3_first_busy", Busy, 0);
    @(negedge CLK);
    chk("t3_second_busy", Busy, 1);
    repeat (5) @(negedge CLK);
    chk("t3_second_tens", Tens, 1);
    chk("t3_second_units", Units, 2);

    // 4: boundary nibble values
    convert(31); chk("t4_31_tens", Tens, 3); chk("t4_31_units", Units, 1);
    convert(19); chk("t4_19_tens", Tens, 1); chk("t4_19_units", Units, 9);
    convert(10); chk("t4_10_tens", Tens, 1); chk("t4_10_units", Units, 0);

    // 5: asynchronous reset in the middle of a conversion
    @(negedge CLK);
    Din = 5'd15;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    chk("t5_rst_busy", Busy, 0);
    chk("t5_rst_tens", Tens, 0);
    chk("t5_rst_units", Units, 0);
    chk("t5_rst_com", Com, 0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    chk("t5_tens", Tens, 1);
    chk("t5_units", Units, 5);

    // 6: leading-zero handling for a single-digit value
    convert(5);
    repeat (2*SCAN_DIV) @(negedge CLK);
`ifdef LEADING_ZERO_BLANK_EN
    slot("t6_tens_slot", 2'b10, 7'h7F);
`else
    slot("t6_tens_slot", 2'b10, 7'h40);
`endif
    slot("t6_units_slot", 2'b01, 7'h12);

    repeat (2) @(negedge CLK);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
